// File: rtl/z80_spimaster_fifo.sv
// Z80 I/O-mapped SPI master: TX FIFO, programmable SCK divider, CPOL/CPHA modes, NUM_CS selects.
// Byte = LOAD + 16*(DIV+1) SHIFT + DONE clk; a DATA write to a full FIFO is dropped and flagged in tx_ovf.
module z80_spimaster_fifo #(
   parameter int NUM_CS     = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_WIDTH  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              iorq_L,
   input  logic              rd_L,
   input  logic              wr_L,
   input  logic [1:0]        a,
   input  logic [7:0]        d,
   output logic [7:0]        d_out,
   output logic              spi_clk,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_CS-1:0] spi_cs
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   logic iorq_q, rd_q, wr_q, wr_prev_q, rd_prev_q, rd_data_q;
   logic [7:0] d_q;
   logic [1:0] a_q;
   logic cpol_q, cpha_q, tx_ovf_q;
   logic [DIV_WIDTH-1:0] div_q;
   logic [NUM_CS-1:0] cs_q;
   logic [7:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0] wptr_q, rptr_q;
   logic [PW:0] cnt_q;

   state_t state_q, state_d;
   logic sclk_q, sclk_d, mosi_q, mosi_d, wcpha_q, wcpha_d;
   logic rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;
   logic [7:0] tsh_q, tsh_d, rsh_q, rsh_d, rx_data_q, rx_data_d;
   logic [DIV_WIDTH-1:0] hcnt_q, hcnt_d, wdiv_q, wdiv_d;
   logic [4:0] edge_q, edge_d, edge_n;
   logic lead;

   wire wr_act      = ~(iorq_q | wr_q);
   wire rd_act      = ~(iorq_q | rd_q);
   wire wr_ev       = wr_act & ~wr_prev_q;
   wire rd_end      = ~rd_act & rd_prev_q;
   wire rd_data_end = rd_end & rd_data_q;
   wire wr_data     = wr_ev & (a_q == 2'd0);
   wire wr_ctrl     = wr_ev & (a_q == 2'd1);
   wire tx_full     = (cnt_q == DEPTH_C);
   wire tx_empty    = (cnt_q == '0);
   wire pop         = (state_q == LOAD);
   // A pop in the same cycle frees the slot, so a write to a full FIFO is still accepted.
   wire push        = wr_data & (~tx_full | pop);
   wire busy        = (state_q != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         iorq_q <= 1'b1; rd_q <= 1'b1; wr_q <= 1'b1;
         wr_prev_q <= 1'b0; rd_prev_q <= 1'b0; rd_data_q <= 1'b0;
         d_q <= '0; a_q <= '0;
         cpol_q <= 1'b0; cpha_q <= 1'b0; tx_ovf_q <= 1'b0;
         div_q <= '0; cs_q <= '0;
         wptr_q <= '0; rptr_q <= '0; cnt_q <= '0;
      end else begin
         iorq_q <= iorq_L; rd_q <= rd_L; wr_q <= wr_L;
         d_q <= d; a_q <= a;
         wr_prev_q <= wr_act;
         rd_prev_q <= rd_act;
         if (rd_act) rd_data_q <= (a_q == 2'd0);
         if (wr_ctrl) begin
            cpol_q <= d_q[0];
            cpha_q <= d_q[1];
            if (d_q[3]) tx_ovf_q <= 1'b0;
         end
         if (wr_data && tx_full && !pop) tx_ovf_q <= 1'b1;
         if (wr_ev && a_q == 2'd2) div_q <= d_q[DIV_WIDTH-1:0];
         if (wr_ev && a_q == 2'd3) cs_q <= d_q[NUM_CS-1:0];
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= d_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE; sclk_q <= 1'b0; mosi_q <= 1'b0; wcpha_q <= 1'b0;
         rx_valid_q <= 1'b0; rx_ovr_q <= 1'b0;
         tsh_q <= '0; rsh_q <= '0; rx_data_q <= '0;
         hcnt_q <= '0; wdiv_q <= '0; edge_q <= '0;
      end else begin
         state_q <= state_d; sclk_q <= sclk_d; mosi_q <= mosi_d; wcpha_q <= wcpha_d;
         rx_valid_q <= rx_valid_d; rx_ovr_q <= rx_ovr_d;
         tsh_q <= tsh_d; rsh_q <= rsh_d; rx_data_q <= rx_data_d;
         hcnt_q <= hcnt_d; wdiv_q <= wdiv_d; edge_q <= edge_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      wcpha_d    = wcpha_q;
      tsh_d      = tsh_q;
      rsh_d      = rsh_q;
      hcnt_d     = hcnt_q;
      wdiv_d     = wdiv_q;
      edge_d     = edge_q;
      edge_n     = edge_q + 5'd1;
      lead       = edge_n[0];
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q & ~rd_data_end;
      rx_ovr_d   = rx_ovr_q & ~(wr_ctrl & d_q[2]);
      case (state_q)
         IDLE: begin
            sclk_d = cpol_q;
            if (!tx_empty) state_d = LOAD;
         end
         LOAD: begin
            tsh_d   = mem_q[rptr_q];
            mosi_d  = mem_q[rptr_q][7];
            sclk_d  = cpol_q;
            wcpha_d = cpha_q;
            wdiv_d  = div_q;
            hcnt_d  = div_q;
            edge_d  = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            if (hcnt_q == '0) begin
               sclk_d = ~sclk_q;
               hcnt_d = wdiv_q;
               edge_d = edge_n;
               if (wcpha_q ? !lead : lead) rsh_d = {rsh_q[6:0], miso};
               if (wcpha_q ? (lead && edge_n >= 5'd3) : (!lead && edge_n <= 5'd14)) begin
                  tsh_d  = {tsh_q[6:0], 1'b0};
                  mosi_d = tsh_q[6];
               end
               if (edge_n == 5'd16) state_d = DONE;
            end else begin
               hcnt_d = hcnt_q - 1'b1;
            end
         end
         DONE: begin
            rx_data_d  = rsh_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rd_data_end) rx_ovr_d = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      logic [7:0] div_ext, cs_ext;
      div_ext = '0;
      div_ext[DIV_WIDTH-1:0] = div_q;
      cs_ext = '0;
      cs_ext[NUM_CS-1:0] = cs_q;
      case (a)
         2'd0:    d_out = rx_data_q;
         2'd1:    d_out = {busy, tx_full, tx_empty, rx_valid_q, rx_ovr_q, tx_ovf_q, cpha_q, cpol_q};
         2'd2:    d_out = div_ext;
         default: d_out = cs_ext;
      endcase
   end

   assign spi_clk = sclk_q;
   assign mosi    = mosi_q;
   assign spi_cs  = ~cs_q;
endmodule

// File: tb/tb_z80_spimaster_fifo.sv
// Directed bench for z80_spimaster_fifo: Z80 bus tasks, SPI edge watcher acting as slave, per-feature tests.
module tb_z80_spimaster_fifo;
   logic clk = 1'b0;
   logic reset, iorq_L, rd_L, wr_L, miso;
   logic [1:0] a;
   logic [7:0] d, d_out;
   logic spi_clk, mosi;
   logic [3:0] spi_cs;
   int tests = 0;
   int fails = 0;

   z80_spimaster_fifo #(.NUM_CS(4), .FIFO_DEPTH(4), .DIV_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .iorq_L(iorq_L), .rd_L(rd_L), .wr_L(wr_L),
      .a(a), .d(d), .d_out(d_out), .spi_clk(spi_clk), .mosi(mosi), .miso(miso), .spi_cs(spi_cs)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1, "timeout");
   end

   task automatic io_write(input logic [1:0] ad, input logic [7:0] dv);
      @(negedge clk);
      a = ad; d = dv; iorq_L = 1'b0; wr_L = 1'b0;
      repeat (3) @(negedge clk);
      iorq_L = 1'b1; wr_L = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic io_read(input logic [1:0] ad, output logic [7:0] dv);
      @(negedge clk);
      a = ad; iorq_L = 1'b0; rd_L = 1'b0;
      repeat (2) @(negedge clk);
      dv = d_out;
      iorq_L = 1'b1; rd_L = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // Counts SCK edges, captures mosi at leading/trailing edges and plays an SPI slave on miso.
   task automatic watch_byte(input logic [7:0] miso_byte, input logic cpha_m, input int stop_edges,
                             input int max_cyc, output int nedge, output logic [7:0] lead_bits,
                             output logic [7:0] trail_bits, output int min_gap, output int max_gap,
                             output logic first_val, output int span);
      logic prev;
      int first_cyc, last_cyc;
      nedge = 0; lead_bits = '0; trail_bits = '0; min_gap = 100000; max_gap = 0;
      first_val = 1'b0; span = 0; first_cyc = 0; last_cyc = 0;
      miso = miso_byte[7];
      prev = spi_clk;
      for (int cyc = 0; cyc < max_cyc && nedge < stop_edges; cyc++) begin
         @(negedge clk);
         if (spi_clk !== prev) begin
            nedge++;
            if (nedge == 1) begin
               first_val = spi_clk;
               first_cyc = cyc;
            end else begin
               if (cyc - last_cyc < min_gap) min_gap = cyc - last_cyc;
               if (cyc - last_cyc > max_gap) max_gap = cyc - last_cyc;
            end
            last_cyc = cyc;
            span = cyc - first_cyc;
            if (nedge % 2 == 1) begin
               lead_bits = {lead_bits[6:0], mosi};
               if (cpha_m && nedge < 16) miso = miso_byte[7 - (nedge - 1) / 2];
            end else begin
               trail_bits = {trail_bits[6:0], mosi};
               if (!cpha_m && nedge < 16) miso = miso_byte[7 - nedge / 2];
            end
         end
         prev = spi_clk;
      end
   endtask

   task automatic wait_idle(output logic ok);
      ok = 1'b0;
      @(negedge clk);
      a = 2'd1;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         if (d_out[7] === 1'b0) ok = 1'b1;
      end
   endtask

   task automatic test_reset;
      logic [7:0] r;
      reset = 1'b1; iorq_L = 1'b1; rd_L = 1'b1; wr_L = 1'b1; a = 2'd0; d = 8'h00; miso = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      tests++; if (spi_cs !== 4'b1111) begin fails++; $display("FAIL reset_cs: got %b want 1111", spi_cs); end
      tests++; if (spi_clk !== 1'b0) begin fails++; $display("FAIL reset_sclk: got %b want 0", spi_clk); end
      tests++; if (mosi !== 1'b0) begin fails++; $display("FAIL reset_mosi: got %b want 0", mosi); end
      io_read(2'd1, r);
      tests++; if (r !== 8'h20) begin fails++; $display("FAIL reset_status: got %h want 20", r); end
      io_read(2'd2, r);
      tests++; if (r !== 8'h00) begin fails++; $display("FAIL reset_div: got %h want 00", r); end
      io_read(2'd0, r);
      tests++; if (r !== 8'h00) begin fails++; $display("FAIL reset_rxdata: got %h want 00", r); end
   endtask

   task automatic test_mode0;
      int ne, mn, mx, sp;
      logic [7:0] lb, tb_bits, r;
      logic fv, ok;
      io_write(2'd3, 8'h01);
      io_write(2'd2, 8'h01);
      io_write(2'd1, 8'h00);
      tests++; if (spi_cs !== 4'b1110) begin fails++; $display("FAIL m0_cs: got %b want 1110", spi_cs); end
      io_read(2'd2, r);
      tests++; if (r !== 8'h01) begin fails++; $display("FAIL m0_div_read: got %h want 01", r); end
      fork
         io_write(2'd0, 8'h55);
         watch_byte(8'hAA, 1'b0, 16, 400, ne, lb, tb_bits, mn, mx, fv, sp);
      join
      tests++; if (ne !== 16) begin fails++; $display("FAIL m0_edges: got %0d want 16", ne); end
      tests++; if (lb !== 8'h55) begin fails++; $display("FAIL m0_mosi_lead: got %h want 55", lb); end
      tests++; if (fv !== 1'b1) begin fails++; $display("FAIL m0_first_edge: got %b want 1", fv); end
      tests++; if (mn !== 2 || mx !== 2) begin fails++; $display("FAIL m0_gap: got %0d..%0d want 2..2", mn, mx); end
      wait_idle(ok);
      tests++; if (ok !== 1'b1) begin fails++; $display("FAIL m0_busy_fall: got %b want 1", ok); end
      io_read(2'd1, r);
      tests++; if (r !== 8'h30) begin fails++; $display("FAIL m0_status: got %h want 30", r); end
      io_read(2'd0, r);
      tests++; if (r !== 8'hAA) begin fails++; $display("FAIL m0_rxdata: got %h want aa", r); end
      io_read(2'd1, r);
      tests++; if (r !== 8'h20) begin fails++; $display("FAIL m0_rxvalid_clr: got %h want 20", r); end
   endtask

   task automatic test_mode3;
      int ne, mn, mx, sp;
      logic [7:0] lb, tb_bits, r;
      logic fv, ok;
      io_write(2'd1, 8'h03);
      io_write(2'd2, 8'h00);
      tests++; if (spi_clk !== 1'b1) begin fails++; $display("FAIL m3_idle_sclk: got %b want 1", spi_clk); end
      fork
         io_write(2'd0, 8'hA5);
         watch_byte(8'hFF, 1'b1, 16, 400, ne, lb, tb_bits, mn, mx, fv, sp);
      join
      tests++; if (ne !== 16) begin fails++; $display("FAIL m3_edges: got %0d want 16", ne); end
      tests++; if (fv !== 1'b0) begin fails++; $display("FAIL m3_first_edge: got %b want 0", fv); end
      tests++; if (tb_bits !== 8'hA5) begin fails++; $display("FAIL m3_mosi_trail: got %h want a5", tb_bits); end
      tests++; if (mn !== 1 || mx !== 1) begin fails++; $display("FAIL m3_gap: got %0d..%0d want 1..1", mn, mx); end
      wait_idle(ok);
      tests++; if (ok !== 1'b1) begin fails++; $display("FAIL m3_busy_fall: got %b want 1", ok); end
      io_read(2'd0, r);
      tests++; if (r !== 8'hFF) begin fails++; $display("FAIL m3_rxdata: got %h want ff", r); end
      io_read(2'd1, r);
      tests++; if (r !== 8'h23) begin fails++; $display("FAIL m3_status: got %h want 23", r); end
   endtask

   task automatic test_back_to_back;
      int ne, mn, mx, sp;
      logic [7:0] lb, tb_bits, r, s0, s1, s2;
      logic fv, ok;
      io_write(2'd1, 8'h00);
      io_write(2'd2, 8'h03);
      fork
         begin
            io_write(2'd0, 8'h11);
            io_write(2'd0, 8'h22);
            io_write(2'd0, 8'h33);
            io_write(2'd0, 8'h44);
            io_write(2'd0, 8'h55);
            io_read(2'd1, s0);
            io_write(2'd0, 8'h66);
            io_read(2'd1, s1);
            io_write(2'd1, 8'h08);
            io_read(2'd1, s2);
         end
         watch_byte(8'h00, 1'b0, 80, 1500, ne, lb, tb_bits, mn, mx, fv, sp);
      join
      tests++; if (s0 !== 8'hC0) begin fails++; $display("FAIL b2b_full_no_ovf: got %h want c0", s0); end
      tests++; if (s1 !== 8'hC4) begin fails++; $display("FAIL b2b_ovf_set: got %h want c4", s1); end
      tests++; if (s2 !== 8'hC0) begin fails++; $display("FAIL b2b_ovf_clr: got %h want c0", s2); end
      tests++; if (ne !== 80) begin fails++; $display("FAIL b2b_edges: got %0d want 80", ne); end
      tests++; if (mn !== 4 || mx !== 7) begin fails++; $display("FAIL b2b_gap: got %0d..%0d want 4..7", mn, mx); end
      tests++; if (sp !== 328) begin fails++; $display("FAIL b2b_span: got %0d want 328", sp); end
      wait_idle(ok);
      tests++; if (ok !== 1'b1) begin fails++; $display("FAIL b2b_busy_fall: got %b want 1", ok); end
      io_read(2'd1, r);
      tests++; if (r !== 8'h38) begin fails++; $display("FAIL b2b_status_end: got %h want 38", r); end
   endtask

   task automatic test_rx_ovr;
      int ne, mn, mx, sp;
      logic [7:0] lb, tb_bits, r;
      logic fv, ok;
      io_write(2'd1, 8'h04);
      io_read(2'd0, r);
      io_read(2'd1, r);
      tests++; if (r !== 8'h20) begin fails++; $display("FAIL ovr_pre: got %h want 20", r); end
      io_write(2'd2, 8'h00);
      fork
         io_write(2'd0, 8'h3C);
         watch_byte(8'h12, 1'b0, 16, 400, ne, lb, tb_bits, mn, mx, fv, sp);
      join
      wait_idle(ok);
      fork
         io_write(2'd0, 8'hC3);
         watch_byte(8'h34, 1'b0, 16, 400, ne, lb, tb_bits, mn, mx, fv, sp);
      join
      wait_idle(ok);
      tests++; if (ok !== 1'b1) begin fails++; $display("FAIL ovr_busy_fall: got %b want 1", ok); end
      io_read(2'd1, r);
      tests++; if (r !== 8'h38) begin fails++; $display("FAIL ovr_set: got %h want 38", r); end
      io_read(2'd0, r);
      tests++; if (r !== 8'h34) begin fails++; $display("FAIL ovr_rxdata: got %h want 34", r); end
      io_read(2'd1, r);
      tests++; if (r !== 8'h28) begin fails++; $display("FAIL ovr_rxvalid_clr: got %h want 28", r); end
      io_write(2'd1, 8'h04);
      io_read(2'd1, r);
      tests++; if (r !== 8'h20) begin fails++; $display("FAIL ovr_clr: got %h want 20", r); end
   endtask

   task automatic test_reset_mid;
      int ne, mn, mx, sp;
      logic [7:0] lb, tb_bits, r;
      logic fv, ok;
      io_write(2'd2, 8'h01);
      io_write(2'd3, 8'h03);
      tests++; if (spi_cs !== 4'b1100) begin fails++; $display("FAIL rm_cs: got %b want 1100", spi_cs); end
      fork
         begin
            io_write(2'd0, 8'hF0);
            io_write(2'd0, 8'h0F);
         end
         watch_byte(8'h00, 1'b0, 7, 400, ne, lb, tb_bits, mn, mx, fv, sp);
      join
      tests++; if (ne !== 7) begin fails++; $display("FAIL rm_edge7: got %0d want 7", ne); end
      reset = 1'b1;
      @(negedge clk);
      tests++; if (spi_clk !== 1'b0) begin fails++; $display("FAIL rm_sclk: got %b want 0", spi_clk); end
      tests++; if (spi_cs !== 4'b1111) begin fails++; $display("FAIL rm_cs_rst: got %b want 1111", spi_cs); end
      tests++; if (mosi !== 1'b0) begin fails++; $display("FAIL rm_mosi: got %b want 0", mosi); end
      reset = 1'b0;
      io_read(2'd1, r);
      tests++; if (r !== 8'h20) begin fails++; $display("FAIL rm_status: got %h want 20", r); end
      fork
         io_write(2'd0, 8'h3C);
         watch_byte(8'h81, 1'b0, 16, 400, ne, lb, tb_bits, mn, mx, fv, sp);
      join
      tests++; if (ne !== 16) begin fails++; $display("FAIL rm_post_edges: got %0d want 16", ne); end
      tests++; if (lb !== 8'h3C) begin fails++; $display("FAIL rm_post_mosi: got %h want 3c", lb); end
      wait_idle(ok);
      io_read(2'd1, r);
      tests++; if (r !== 8'h30) begin fails++; $display("FAIL rm_post_status: got %h want 30", r); end
      io_read(2'd0, r);
      tests++; if (r !== 8'h81) begin fails++; $display("FAIL rm_post_rxdata: got %h want 81", r); end
   endtask

   initial begin
      test_reset;
      test_mode0;
      test_mode3;
      test_back_to_back;
      test_rx_ovr;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
